// File: rtl/lab_arith_pkg.sv
// Shared definitions for the lab arithmetic blocks: FSM state encoding and default operand width.
package lab_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder, the dual of the lab full subtractor cell.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// Latency: done is high in the cycle after edge E0+WIDTH, where E0 is the accepting edge.
// Backpressure: start is ignored while busy; a start seen in the DONE cycle is taken back-to-back.
module serial_full_adder
    import lab_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic               load;
    logic               last_bit;
    logic [WIDTH-1:0]   a_sr, b_sr, sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               bit_s, bit_co;

    full_adder_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sum/cout are loaded from the final shift value so they never expose partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
            carry  <= bit_co;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= {bit_s, sum_sr[WIDTH-1:1]};
                cout <= bit_co;
            end
        end
    end

endmodule
